// File: rtl/axi_slave_ram.sv
// AXI4 responder backed by a 64-bit register-array RAM.
// Serves as the far end of an AXI master for simulation/FPGA bring-up or as scratch memory.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN   clock, async active-low reset
//   S_AXI_AW*                    write address channel (PROT ignored)
//   S_AXI_W*                     write data channel (64-bit data, 8-bit strobe)
//   S_AXI_B*                     write response channel
//   S_AXI_AR*                    read address channel (PROT ignored)
//   S_AXI_R*                     read data channel
// Read and write channels run independent FSMs and may be active together.
module axi_slave_ram #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]            S_AXI_AWLEN,
  input  logic [2:0]            S_AXI_AWSIZE,
  input  logic [1:0]            S_AXI_AWBURST,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [63:0]           S_AXI_WDATA,
  input  logic [7:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WLAST,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]            S_AXI_ARLEN,
  input  logic [2:0]            S_AXI_ARSIZE,
  input  logic [1:0]            S_AXI_ARBURST,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [63:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RLAST,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned IDX_LO = 3;
  localparam int unsigned IDX_HI = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  // Beat address step: INCR and WRAP both increment, FIXED/reserved hold
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    if (burst == 2'b01 || burst == 2'b10) return addr + (ADDR_WIDTH'(1) << size);
    return addr;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------- write channel ----------------
  wstate_t               r_wstate, w_wstate_nxt;
  logic                  r_awready, w_awready_nxt;
  logic                  r_wready, w_wready_nxt;
  logic                  r_bvalid, w_bvalid_nxt;
  logic [1:0]            r_bresp, w_bresp_nxt;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wlen;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst;
  logic [7:0]            r_wcnt;
  logic                  r_werr;

  logic                  w_awhs, w_wbeat, w_wlast_beat, w_wlast_err;
  logic [DEPTH_LOG2-1:0] w_widx;

  assign w_awhs       = S_AXI_AWVALID & r_awready;
  assign w_wbeat      = S_AXI_WVALID & r_wready;
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_wlast_err  = (S_AXI_WLAST != w_wlast_beat);
  assign w_widx       = r_waddr[IDX_HI:IDX_LO];

  // Write FSM next-state and registered-output next values
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    case (r_wstate)
      W_IDLE: begin
        w_awready_nxt = 1'b1;
        if (w_awhs) begin
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b1;
          w_wstate_nxt  = W_DATA;
        end
      end
      W_DATA: begin
        // Burst ends on beat count alone; a WLAST mismatch only flags SLVERR
        if (w_wbeat && w_wlast_beat) begin
          w_wready_nxt = 1'b0;
          w_bvalid_nxt = 1'b1;
          w_bresp_nxt  = (r_werr | w_wlast_err) ? 2'b10 : 2'b00;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY && r_bvalid) begin
          w_bvalid_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wstate_nxt  = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM state and output registers
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // Write burst context: address, length, beat counter, WLAST error flag
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
    end else if (r_wstate == W_IDLE && w_awhs) begin
      r_waddr  <= S_AXI_AWADDR;
      r_wlen   <= S_AXI_AWLEN;
      r_wsize  <= S_AXI_AWSIZE;
      r_wburst <= S_AXI_AWBURST;
      r_wcnt   <= 8'd0;
      r_werr   <= 1'b0;
    end else if (r_wstate == W_DATA && w_wbeat) begin
      r_waddr  <= f_next_addr(r_waddr, r_wsize, r_wburst);
      r_wcnt   <= r_wcnt + 8'd1;
      r_werr   <= r_werr | w_wlast_err;
    end
  end

  // RAM write port: lanes taken as presented, unstrobed lanes untouched
  always_ff @(posedge S_AXI_ACLK) begin
    if (r_wstate == W_DATA && w_wbeat) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (S_AXI_WSTRB[i]) r_mem[w_widx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t               r_rstate, w_rstate_nxt;
  logic                  r_arready, w_arready_nxt;
  logic                  r_rvalid, w_rvalid_nxt;
  logic                  r_rlast, w_rlast_nxt;
  logic [1:0]            r_rresp, w_rresp_nxt;
  logic [DATA_W-1:0]     r_rdata;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rlen;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic [7:0]            r_rcnt;

  logic                  w_arhs, w_rhs, w_rload;
  logic [ADDR_WIDTH-1:0] w_raddr_adv;
  logic [DEPTH_LOG2-1:0] w_ridx;

  assign w_arhs      = S_AXI_ARVALID & r_arready;
  assign w_rhs       = r_rvalid & S_AXI_RREADY;
  assign w_raddr_adv = f_next_addr(r_raddr, r_rsize, r_rburst);

  // Read FSM next-state; w_rload/w_ridx select the word fetched this edge
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rlast_nxt   = r_rlast;
    w_rresp_nxt   = r_rresp;
    w_rload       = 1'b0;
    w_ridx        = w_raddr_adv[IDX_HI:IDX_LO];
    case (r_rstate)
      R_IDLE: begin
        w_arready_nxt = 1'b1;
        if (w_arhs) begin
          w_arready_nxt = 1'b0;
          w_rvalid_nxt  = 1'b1;
          w_rlast_nxt   = (S_AXI_ARLEN == 8'd0);
          w_rresp_nxt   = 2'b00;
          w_rload       = 1'b1;
          w_ridx        = S_AXI_ARADDR[IDX_HI:IDX_LO];
          w_rstate_nxt  = R_DATA;
        end
      end
      R_DATA: begin
        if (w_rhs) begin
          if (r_rlast) begin
            w_rvalid_nxt  = 1'b0;
            w_rlast_nxt   = 1'b0;
            w_arready_nxt = 1'b1;
            w_rstate_nxt  = R_IDLE;
          end else begin
            w_rload     = 1'b1;
            w_rlast_nxt = ((r_rcnt + 8'd1) == r_rlen);
          end
        end
      end
    endcase
  end

  // Read FSM state and output registers; RAM read sees pre-write contents
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rlast   <= w_rlast_nxt;
      r_rresp   <= w_rresp_nxt;
      if (w_rload) r_rdata <= r_mem[w_ridx];
    end
  end

  // Read burst context
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rcnt   <= '0;
    end else if (r_rstate == R_IDLE && w_arhs) begin
      r_raddr  <= S_AXI_ARADDR;
      r_rlen   <= S_AXI_ARLEN;
      r_rsize  <= S_AXI_ARSIZE;
      r_rburst <= S_AXI_ARBURST;
      r_rcnt   <= 8'd0;
    end else if (r_rstate == R_DATA && w_rhs && !r_rlast) begin
      r_raddr  <= w_raddr_adv;
      r_rcnt   <= r_rcnt + 8'd1;
    end
  end

  // PROT is accepted but has no effect
  logic w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RLAST   = r_rlast;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;

endmodule

// File: doc/axi_slave_ram.md
Name: axi_slave_ram

Overview:
- AXI4 responder (slave) backed by a 64-bit-wide internal register-array RAM.
- It is the far end of the team's AXI master bus interface. It lets that master be simulated and tested on FPGA without a DDR/BRAM controller, and it can also serve as a scratch memory.
- Supports single-beat narrow accesses (size 0..3) and INCR bursts of up to 256 beats.
- Read and write channels are independent and may be active at the same time.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 64-bit words (default 1024 words = 8 KiB).
- ADDR_WIDTH, 32, width of AWADDR/ARADDR.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AWADDR  in  ADDR_WIDTH  write start byte address.
- S_AXI_AWLEN  in  8  beats-1.
- S_AXI_AWSIZE  in  3  bytes/beat = 1<<size.
- S_AXI_AWBURST  in  2  burst type.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 ; S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  64 ; S_AXI_WSTRB  in  8 ; S_AXI_WLAST  in  1.
- S_AXI_WVALID  in  1 ; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2 ; S_AXI_BVALID  out  1 ; S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  ADDR_WIDTH ; S_AXI_ARLEN  in  8 ; S_AXI_ARSIZE  in  3 ; S_AXI_ARBURST  in  2 ; S_AXI_ARPROT  in  3 (ignored).
- S_AXI_ARVALID  in  1 ; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  64 ; S_AXI_RRESP  out  2 ; S_AXI_RLAST  out  1 ; S_AXI_RVALID  out  1 ; S_AXI_RREADY  in  1.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are registered and reset to 0: AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST, RRESP, RDATA.
  - Both FSMs go to IDLE.
  - RAM contents are not cleared.
  - AWREADY/ARREADY rise on the first clock after release.
  - Reset mid-burst abandons the burst; no B or R beat is issued for it.
- Word index = byte address[DEPTH_LOG2+2:3]. Upper bits are discarded, so addresses alias modulo 8 KiB (default).
- Beat address update:
  - INCR (01) and WRAP (10): addr += (1<<size), computed in ADDR_WIDTH bits with natural wrap. WRAP is treated as INCR.
  - FIXED (00) and reserved (11): addr unchanged.
  - Narrow beats advance the word index only when crossing an 8-byte boundary.
- Write FSM:
  - W_IDLE: AWREADY=1.
    - On AWVALID&AWREADY, latch addr/len/size/burst, clear the beat counter and error flag, then AWREADY=0, WREADY=1, go to W_DATA.
  - W_DATA: on each WVALID&WREADY:
    - Write each byte lane i where WSTRB[i]=1; lanes with WSTRB[i]=0 keep their old value.
    - Data is not lane-shifted; strobes select lanes as presented.
    - A beat is last when the counter equals len.
    - Set the error flag if WLAST != last-ness on any beat.
    - On the last beat: WREADY=0, BVALID=1, BRESP = error ? 2'b10 (SLVERR) : 2'b00, go to W_RESP.
    - Termination depends only on the beat count, never on WLAST.
  - W_RESP: hold BVALID until BREADY. On handshake, BVALID=0, AWREADY=1, go to W_IDLE.
  - Next AW is accepted no earlier than the cycle after the B handshake.
  - W beats arriving while in W_IDLE are not accepted (WREADY=0).
- Read FSM:
  - R_IDLE: ARREADY=1.
    - On ARVALID&ARREADY, on the same edge load RDATA <= mem[ARADDR index], RLAST <= (ARLEN==0), RVALID <= 1, RRESP=00, ARREADY=0, go to R_DATA.
    - Latency: RVALID is high the cycle after the AR handshake.
  - R_DATA: while RVALID & ~RREADY, hold RDATA/RLAST stable.
    - On RVALID&RREADY and not last: advance address and load the next word the same edge. This gives 1 beat/cycle with RREADY held high. Update RLAST for the final beat.
    - On RVALID&RREADY and last: RVALID=0, RLAST=0, ARREADY=1, go to R_IDLE.
- Simultaneous read and write of the same word on one edge: read returns the pre-write data.
- AWLEN=255 and ARLEN=255 are supported. The beat counter is 8 bits, compared against the latched len.

Test Plan:
- Single write then read:
  - Stimulus: AW addr 0x10, len 0, size 3, WDATA 0x1122334455667788, WSTRB 0xFF, WLAST 1; B handshake; then AR addr 0x10 len 0.
  - Required: BRESP 00; RVALID one cycle after the AR handshake; RDATA 0x1122334455667788; RLAST 1.
- Byte write:
  - Stimulus: after the word above, write addr 0x13 size 0, WDATA 0xFFFFFFFFFFFFFFFF, WSTRB 0x08.
  - Required: readback 0x11223344FF667788.
- Burst:
  - Stimulus: write addr 0x100 len 7, data k*0x0101010101010101 (k=1..8), WLAST on beat 8; read burst addr 0x100 len 7 with RREADY stuck high.
  - Required: 8 consecutive R beats in 8 cycles, same data in order, RLAST only on beat 8.
- Backpressure:
  - Stimulus: same read with RREADY toggling 1,0,0,1...; BREADY held low 5 cycles.
  - Required: RDATA/RLAST stable while stalled, no beat lost or duplicated; BVALID held 5 cycles; AWREADY stays 0 until the B handshake.
- Protocol error and alias:
  - Stimulus: write len 3 with WLAST asserted on beat 2; separately, write addr 0x2000 then read addr 0x0000.
  - Required: 4 beats still accepted, BRESP 10; the read returns the 0x2000 data (default depth aliasing).
- Reset and concurrency:
  - Stimulus: deassert ARESETN during beat 3 of an 8-beat read; after release, issue a write to addr 0x40 and a read of 0x40 on the same cycle.
  - Required: RVALID 0 immediately on reset; ARREADY 1 one cycle after release; the concurrent read returns the old data.
